// File: rtl/csr_tohost_if.sv
// CSR-side write port and host-side FIFO drain port of the tohost reader.
// The slave modport is the reader itself; the master modport is the core/host side.
interface csr_tohost_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic              csr_we;
  logic [11:0]       csr_addr;
  logic [2:0]        csr_func;
  logic [DWIDTH-1:0] csr_data_in;
  logic [DWIDTH-1:0] csr_rdata;

  logic              host_valid;
  logic [DWIDTH-1:0] host_data;
  logic              host_ready;

  logic              overflow;
  logic              overflow_clr;
  logic [LW-1:0]     level;

  modport slave (
    input  csr_we, csr_addr, csr_func, csr_data_in, host_ready, overflow_clr,
    output csr_rdata, host_valid, host_data, overflow, level
  );

  modport master (
    output csr_we, csr_addr, csr_func, csr_data_in, host_ready, overflow_clr,
    input  csr_rdata, host_valid, host_data, overflow, level
  );
endinterface

// File: rtl/csr_tohost_reader.sv
// Shadow register for the tohost CSR; every write event is queued in a small FIFO
// for the host to drain, with a sticky overflow flag when a write finds no space.
module csr_tohost_reader #(
  parameter int unsigned DWIDTH      = 32,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int unsigned DEPTH       = 4
) (
  input logic          clk,
  input logic          rst_n,
  csr_tohost_if.slave  bus_io
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  logic [DWIDTH-1:0] shadow_q, shadow_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;

  logic              func_ok;
  logic              wr_event;
  logic [DWIDTH-1:0] new_val;
  logic              full;
  logic              pop;
  logic              push;

  // Decode: funct3 000 and 100 are not CSR read-modify-write forms.
  always_comb begin
    func_ok = 1'b0;
    new_val = shadow_q;
    unique case (bus_io.csr_func[1:0])
      2'b01: begin
        func_ok = 1'b1;
        new_val = bus_io.csr_data_in;
      end
      2'b10: begin
        func_ok = 1'b1;
        new_val = shadow_q | bus_io.csr_data_in;
      end
      2'b11: begin
        func_ok = 1'b1;
        new_val = shadow_q & ~bus_io.csr_data_in;
      end
      default: begin
        func_ok = 1'b0;
        new_val = shadow_q;
      end
    endcase
  end

  assign wr_event = bus_io.csr_we && (bus_io.csr_addr == TOHOST_ADDR) && func_ok;

  // Control derives only from level/pointers, never from RAM contents.
  assign full = (level_q == FullLevel);
  assign pop  = (level_q != '0) && bus_io.host_ready;
  assign push = wr_event && (!full || pop);

  always_comb begin
    shadow_d   = wr_event ? new_val : shadow_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // A dropped write beats a simultaneous clear.
    overflow_d = overflow_q;
    if (wr_event && !push) begin
      overflow_d = 1'b1;
    end else if (bus_io.overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem_q[wr_ptr_q] <= new_val;
    end
  end

  assign bus_io.csr_rdata  = shadow_q;
  assign bus_io.host_valid = (level_q != '0);
  assign bus_io.host_data  = mem_q[rd_ptr_q];
  assign bus_io.overflow   = overflow_q;
  assign bus_io.level      = level_q;

endmodule
